neuron_buffer_loader: RTL and testbench

- Host-side controller that drives the neuron buffer IO port, i.e. the packed ioInputs bus {ioSelect, ioWrite, ioBankSelect, ioInput}, plus the shared address bus.
- Write mode: scatters a valid/ready word stream across the D banks.
- Read mode: gathers the banks back into a valid/ready output stream.
- Sits between the external DMA/host stream and the neuron buffer; the convolution datapath never sees it.

---
 rtl/nbl_pkg.sv | 29 ++
 rtl/nbl_index_gen.sv | 43 ++++
 rtl/neuron_buffer_loader.sv | 164 ++++++++++++++++
 tb/tb_neuron_buffer_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nbl_pkg.sv
// Shared types and ioInputs field positions for the neuron buffer loader.
package nbl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_HOLD,
        ST_FIN
    } nbl_state_t;

    localparam logic MODE_WR = 1'b1;
    localparam logic MODE_RD = 1'b0;

    // Field offsets depend on the instance's W/depth, so they are functions.
    function automatic int sel_bit(input int w, input int d);
        return w + d + 1;
    endfunction

    function automatic int wr_bit(input int w, input int d);
        return w + d;
    endfunction

    function automatic int bank_msb(input int w, input int d);
        return w + d - 1;
    endfunction

endpackage

// File: rtl/nbl_index_gen.sv
// Word index counter: latches base/count, yields bank, row address and last-word flag.
module nbl_index_gen
    import nbl_pkg::*;
#(
    parameter int depth = 2,
    parameter int A     = 7,
    parameter int CW    = A + depth
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             advance,
    input  logic [A-1:0]     base_addr,
    input  logic [CW-1:0]    word_count,
    output logic [depth-1:0] bank,
    output logic [A-1:0]     address,
    output logic             last
);

    logic [CW-1:0] idx;
    logic [A-1:0]  base_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx    <= '0;
            base_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            idx    <= '0;
            base_q <= base_addr;
            cnt_q  <= word_count;
        end else if (advance) begin
            idx <= idx + CW'(1);
        end
    end

    // Upper index bits are exactly A wide, so the sum wraps modulo 2^A.
    assign bank    = idx[depth-1:0];
    assign address = base_q + idx[CW-1:depth];
    assign last    = (idx == cnt_q - CW'(1));

endmodule

// File: rtl/neuron_buffer_loader.sv
// Host-side scatter/gather controller for the neuron buffer IO port.
// Optional build macro: NBL_RANGE_CHECK_EN (reject transfers running past the last row).
module neuron_buffer_loader
    import nbl_pkg::*;
#(
    parameter int depth  = 2,
    parameter int A      = 7,
    parameter int W      = 16,
    parameter int RD_LAT = 1,
    parameter int CW     = A + depth
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               mode,
    input  logic [A-1:0]       base_addr,
    input  logic [CW-1:0]      word_count,
    input  logic [W-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W+depth+1:0] ioInputs,
    input  logic [W-1:0]       ioOutputs,
    output logic [A-1:0]       address,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int SEL_B  = sel_bit(W, depth);
    localparam int WR_B   = wr_bit(W, depth);
    localparam int BANK_M = bank_msb(W, depth);
    localparam int WCW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    nbl_state_t       state;
    logic [WCW-1:0]   wcnt;
    logic             accept;
    logic             advance;
    logic             range_bad;
    logic [depth-1:0] ig_bank;
    logic [A-1:0]     ig_addr;
    logic             ig_last;

    assign accept  = (state == ST_IDLE) && start;
    assign advance = ((state == ST_WR) && in_valid) || ((state == ST_RD_HOLD) && out_ready);

    nbl_index_gen #(
        .depth(depth),
        .A    (A),
        .CW   (CW)
    ) u_index (
        .CLK       (CLK),
        .RST       (RST),
        .load      (accept),
        .advance   (advance),
        .base_addr (base_addr),
        .word_count(word_count),
        .bank      (ig_bank),
        .address   (ig_addr),
        .last      (ig_last)
    );

`ifdef NBL_RANGE_CHECK_EN
    localparam int RW = CW + 2;
    localparam int D  = 1 << depth;

    logic [RW-1:0] rows;
    logic          err_q;

    always_comb begin
        rows      = (RW'(word_count) + RW'(D - 1)) >> depth;
        range_bad = (RW'(base_addr) + rows) > (RW'(1) << A);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_q <= 1'b0;
        else if (accept)
            err_q <= range_bad;
    end

    assign error = err_q;
`else
    assign range_bad = 1'b0;
    assign error     = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            wcnt      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count == '0 || range_bad)
                            state <= ST_FIN;
                        else if (mode == MODE_WR)
                            state <= ST_WR;
                        else
                            state <= ST_RD_ISSUE;
                    end
                end
                ST_WR: begin
                    if (in_valid && ig_last)
                        state <= ST_FIN;
                end
                ST_RD_ISSUE: begin
                    wcnt  <= '0;
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (wcnt == WCW'(RD_LAT - 1)) begin
                        out_data  <= ioOutputs;
                        out_valid <= 1'b1;
                        state     <= ST_RD_HOLD;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                ST_RD_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ig_last ? ST_FIN : ST_RD_ISSUE;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready = (state == ST_WR);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_FIN);

    // Writes follow in_valid combinationally so the buffer captures on the handshake edge.
    always_comb begin
        ioInputs = '0;
        address  = '0;
        case (state)
            ST_WR: begin
                if (in_valid) begin
                    ioInputs[SEL_B]              = 1'b1;
                    ioInputs[WR_B]               = 1'b1;
                    ioInputs[BANK_M -: depth]    = ig_bank;
                    ioInputs[W-1:0]              = in_data;
                    address                      = ig_addr;
                end
            end
            ST_RD_ISSUE, ST_RD_WAIT: begin
                ioInputs[SEL_B]           = 1'b1;
                ioInputs[BANK_M -: depth] = ig_bank;
                address                   = ig_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_neuron_buffer_loader.sv
// Directed bench for neuron_buffer_loader with a behavioural neuron buffer (RD_LAT=1).
module tb_neuron_buffer_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        mode;
    logic [6:0]  base_addr;
    logic [8:0]  word_count;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] ioInputs;
    logic [15:0] ioOutputs;
    logic [6:0]  address;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    neuron_buffer_loader #(
        .depth (2),
        .A     (7),
        .W     (16),
        .RD_LAT(1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .word_count(word_count),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ioInputs  (ioInputs),
        .ioOutputs (ioOutputs),
        .address   (address),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 CLK = ~CLK;

    logic [15:0] mem [0:3][0:127];
    logic [15:0] rdata = '0;
    int          sel_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          nlog = 0;
    logic [1:0]  log_bank [0:63];
    logic [6:0]  log_addr [0:63];
    logic [15:0] log_data [0:63];

    assign ioOutputs = rdata;

    // Buffer model: writes on the select+write edge, reads appear one cycle after issue.
    always @(posedge CLK) begin
        if (ioInputs[19]) sel_cnt++;
        if (ioInputs[19] && ioInputs[18]) begin
            mem[ioInputs[17:16]][address] <= ioInputs[15:0];
            if (nlog < 64) begin
                log_bank[nlog] = ioInputs[17:16];
                log_addr[nlog] = address;
                log_data[nlog] = ioInputs[15:0];
            end
            nlog++;
            wr_cnt++;
        end
        if (ioInputs[19] && !ioInputs[18]) rdata <= mem[ioInputs[17:16]][address];
        if (done) done_cnt++;
    end

    task automatic clear_mon();
        sel_cnt  = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        nlog     = 0;
    endtask

    task automatic issue_cmd(input logic m, input logic [6:0] b, input logic [8:0] n);
        start      = 1'b1;
        mode       = m;
        base_addr  = b;
        word_count = n;
        @(posedge CLK); #1;
        start      = 1'b0;
        mode       = ~m;
        base_addr  = 7'h55;
        word_count = 9'h1ff;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 0; mode = 0; base_addr = 0; word_count = 0;
        in_data = 0; in_valid = 0; out_ready = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++; if (ioInputs !== 20'h0) begin bad++; $display("FAIL reset_io got=%h exp=0", ioInputs); end
        total++; if (address !== 7'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", address); end
        total++; if ({in_ready, out_valid, busy, done, error} !== 5'b0)
            begin bad++; $display("FAIL reset_flags got=%b exp=00000", {in_ready, out_valid, busy, done, error}); end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_write8();
        logic [1:0] eb;
        logic [6:0] ea;
        clear_mon();
        in_valid = 1'b1;
        in_data  = 16'h1000;
        issue_cmd(1'b1, 7'd5, 9'd8);
        for (int k = 0; k < 8; k++) begin
            in_data = 16'h1000 + 16'(k);
            @(negedge CLK);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wr_ready k=%0d got=%b exp=1", k, in_ready); end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        @(negedge CLK);
        total++; if ({done, busy} !== 2'b11) begin bad++; $display("FAIL wr_done got=%b exp=11", {done, busy}); end
        @(posedge CLK); #1;
        @(negedge CLK);
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL wr_idle got=%b exp=00", {done, busy}); end
        total++; if (wr_cnt !== 8) begin bad++; $display("FAIL wr_count got=%0d exp=8", wr_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL wr_done_cnt got=%0d exp=1", done_cnt); end
        for (int k = 0; k < 8; k++) begin
            eb = 2'(k % 4);
            ea = (k < 4) ? 7'd5 : 7'd6;
            total++;
            if (log_bank[k] !== eb || log_addr[k] !== ea || log_data[k] !== 16'h1000 + 16'(k)) begin
                bad++;
                $display("FAIL wr_word k=%0d got=b%0d a%0d %h exp=b%0d a%0d %h", k,
                         log_bank[k], log_addr[k], log_data[k], eb, ea, 16'h1000 + 16'(k));
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_read8();
        int          n = 0;
        logic        held = 1'b0;
        logic [15:0] held_data = '0;
        logic        fin = 1'b0;
        clear_mon();
        out_ready = 1'b1;
        issue_cmd(1'b0, 7'd5, 9'd8);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge CLK);
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held_data) begin
                    bad++;
                    $display("FAIL rd_stable got=%b/%h exp=1/%h", out_valid, out_data, held_data);
                end
            end
            if (done) fin = 1'b1;
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    total++;
                    if (out_data !== 16'h1000 + 16'(n)) begin
                        bad++; $display("FAIL rd_data n=%0d got=%h exp=%h", n, out_data, 16'h1000 + 16'(n));
                    end
                    n++;
                end else begin
                    held      = 1'b1;
                    held_data = out_data;
                end
            end
            @(posedge CLK); #1;
            out_ready = ~out_ready;
        end
        out_ready = 1'b0;
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL rd_timeout got=%b exp=1", fin); end
        total++; if (n !== 8) begin bad++; $display("FAIL rd_words got=%0d exp=8", n); end
        total++; if (wr_cnt !== 0) begin bad++; $display("FAIL rd_no_write got=%0d exp=0", wr_cnt); end
        @(posedge CLK); #1;
    endtask

    task automatic test_zero_count();
        for (int m = 1; m >= 0; m--) begin
            clear_mon();
            in_valid = 1'b1;
            issue_cmd(1'(m), 7'd9, 9'd0);
            @(negedge CLK);
            total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done m=%0d got=%b exp=1", m, done); end
            @(posedge CLK); #1;
            @(negedge CLK);
            total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL zero_idle m=%0d got=%b exp=00", m, {done, busy}); end
            total++; if (sel_cnt !== 0) begin bad++; $display("FAIL zero_sel m=%0d got=%0d exp=0", m, sel_cnt); end
            in_valid = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_wrap();
        logic [6:0] ea [0:5];
        ea = '{7'd127, 7'd127, 7'd127, 7'd127, 7'd0, 7'd0};
        clear_mon();
        in_valid = 1'b1;
        issue_cmd(1'b1, 7'd127, 9'd6);
        for (int k = 0; k < 6; k++) begin
            in_data = 16'h3000 + 16'(k);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge CLK); #1;
        @(negedge CLK);
`ifdef NBL_RANGE_CHECK_EN
        total++; if (error !== 1'b1) begin bad++; $display("FAIL wrap_error got=%b exp=1", error); end
        total++; if (sel_cnt !== 0) begin bad++; $display("FAIL wrap_access got=%0d exp=0", sel_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL wrap_done got=%0d exp=1", done_cnt); end
`else
        total++; if (error !== 1'b0) begin bad++; $display("FAIL wrap_error got=%b exp=0", error); end
        total++; if (wr_cnt !== 6) begin bad++; $display("FAIL wrap_count got=%0d exp=6", wr_cnt); end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (log_addr[k] !== ea[k] || log_bank[k] !== 2'(k % 4)) begin
                bad++;
                $display("FAIL wrap_addr k=%0d got=a%0d b%0d exp=a%0d b%0d", k, log_addr[k], log_bank[k], ea[k], k % 4);
            end
        end
`endif
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        in_valid = 1'b1;
        issue_cmd(1'b1, 7'd10, 9'd8);
        for (int k = 0; k < 3; k++) begin
            in_data = 16'h4000 + 16'(k);
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        #1;
        total++; if (ioInputs !== 20'h0 || address !== 7'h0) begin bad++; $display("FAIL rstmid_io got=%h/%h exp=0/0", ioInputs, address); end
        total++; if ({in_ready, busy, done, out_valid, error} !== 5'b0)
            begin bad++; $display("FAIL rstmid_flags got=%b exp=00000", {in_ready, busy, done, out_valid, error}); end
        repeat (2) @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        total++; if (wr_cnt !== 3) begin bad++; $display("FAIL rstmid_writes got=%0d exp=3", wr_cnt); end
        clear_mon();
        issue_cmd(1'b1, 7'd20, 9'd4);
        for (int k = 0; k < 4; k++) begin
            in_data = 16'h2000 + 16'(k);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        @(posedge CLK); #1;
        total++; if (wr_cnt !== 4 || done_cnt !== 1) begin bad++; $display("FAIL rstmid_rerun got=w%0d d%0d exp=w4 d1", wr_cnt, done_cnt); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (log_bank[k] !== 2'(k) || log_addr[k] !== 7'd20 || log_data[k] !== 16'h2000 + 16'(k)) begin
                bad++;
                $display("FAIL rstmid_word k=%0d got=b%0d a%0d %h exp=b%0d a20 %h", k,
                         log_bank[k], log_addr[k], log_data[k], k, 16'h2000 + 16'(k));
            end
        end
    endtask

    task automatic test_start_ignored();
        int   n = 0;
        logic fin = 1'b0;
        clear_mon();
        out_ready = 1'b1;
        issue_cmd(1'b0, 7'd5, 9'd4);
        total++; if (error !== 1'b0) begin bad++; $display("FAIL ign_error got=%b exp=0", error); end
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            if (cyc >= 1 && cyc <= 5) begin
                start = 1'b1; mode = 1'b1; base_addr = 7'd0; word_count = 9'd1; in_valid = 1'b1;
            end else begin
                start = 1'b0; in_valid = 1'b0;
            end
            @(negedge CLK);
            if (done) fin = 1'b1;
            if (out_valid && out_ready) begin
                total++;
                if (out_data !== 16'h1000 + 16'(n)) begin
                    bad++; $display("FAIL ign_data n=%0d got=%h exp=%h", n, out_data, 16'h1000 + 16'(n));
                end
                n++;
            end
            @(posedge CLK); #1;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge CLK);
        total++; if (fin !== 1'b1 || n !== 4) begin bad++; $display("FAIL ign_words got=f%b n%0d exp=f1 n4", fin, n); end
        total++; if (wr_cnt !== 0 || busy !== 1'b0) begin bad++; $display("FAIL ign_nowrite got=w%0d b%b exp=w0 b0", wr_cnt, busy); end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_write8();
        test_read8();
        test_zero_count();
        test_wrap();
        test_reset_mid();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
